// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter/sequencer for a shared 4:1 one-bit select path.
// Grants one requester at a time, drives the two-level select pair, bounds hold time.
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] d,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       o
);

    localparam int unsigned CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [1:0]       r_sel;
    logic [3:0]       r_gnt;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;

    logic             w_own_req;
    logic [3:0]       w_others;
    logic [2:0]       w_idle_pick;
    logic [2:0]       w_hand_pick;
    logic             w_release;

    // {found, index} of the first set bit of cand, scanning start, start+1, ... mod 4
    function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] k;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            k = start + 2'(i);
            if (cand[k]) begin
                res = {1'b1, k};
            end
        end
        return res;
    endfunction

    // r_sel doubles as the current owner while a grant is active
    always_comb begin
        w_own_req   = req[r_sel];
        w_others    = req & ~(4'b0001 << r_sel);
        w_idle_pick = rr_pick(req, r_ptr);
        w_hand_pick = rr_pick(w_others, r_sel + 2'd1);
        w_release   = !w_own_req || ((r_cnt == CNT_MAX) && (w_others != 4'b0000));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= 2'd0;
            r_sel   <= 2'd0;
            r_gnt   <= 4'b0000;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_idle_pick[2]) begin
                        r_state <= GRANT;
                        r_sel   <= w_idle_pick[1:0];
                        r_gnt   <= 4'b0001 << w_idle_pick[1:0];
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_ptr <= r_sel + 2'd1;
                        if (w_hand_pick[2]) begin
                            // Direct handoff: no idle bubble between owners
                            r_sel <= w_hand_pick[1:0];
                            r_gnt <= 4'b0001 << w_hand_pick[1:0];
                            r_cnt <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_gnt   <= 4'b0000;
                            r_busy  <= 1'b0;
                        end
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt  = r_gnt;
    assign sel  = r_sel;
    assign busy = r_busy;
    assign o    = r_busy ? d[r_sel] : 1'b0;

endmodule
